// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// Module   : fetch_unit_pkg
// Purpose  : Shared types for the instruction fetch front-end.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

   typedef logic [31:0] addr_t;

   typedef struct packed {
      addr_t       pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_packet;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_queue.sv
// ----------------------------------------------------------------------------
// Module   : fetch_unit_queue
// Purpose  : Generic valid/ready FIFO with optional fall-through and pipelined
//            full-push; DEPTH must be a power of two.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit_queue #(
   parameter type DATA_T      = logic [31:0],
   parameter int  DEPTH       = 4,
   parameter bit  FALLTHROUGH = 1'b0,
   parameter bit  PIPE        = 1'b0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  flush,
   input  logic  in_valid,
   output logic  in_ready,
   input  DATA_T in_data,
   output logic  out_valid,
   input  logic  out_ready,
   output DATA_T out_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   DATA_T         mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          bypass;
   logic          wr_en;
   logic          rd_en;

   // Extra pointer bit distinguishes full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   generate
      if (FALLTHROUGH) begin : g_fallthrough
         assign out_valid = !empty || in_valid;
         assign out_data  = empty ? in_data : mem[rd_ptr[AW-1:0]];
         assign bypass    = empty && in_valid && out_ready;
      end else begin : g_registered
         assign out_valid = !empty;
         assign out_data  = mem[rd_ptr[AW-1:0]];
         assign bypass    = 1'b0;
      end
   endgenerate

   generate
      if (PIPE) begin : g_pipe
         assign in_ready = !full || out_ready;
      end else begin : g_no_pipe
         assign in_ready = !full;
      end
   endgenerate

   assign wr_en = in_valid && in_ready && !bypass && !flush;
   assign rd_en = out_valid && out_ready && !empty && !flush;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Credit-based instruction fetch front-end with redirect handling.
//            Define FETCH_BYPASS_EN for 0-cycle response-to-output bypass.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter addr_t RESET_PC        = 32'h8000_0000,
   parameter int    MAX_OUTSTANDING = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  addr_t       redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output addr_t       mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output fetch_packet out_data
);

   localparam int             CW         = $clog2(MAX_OUTSTANDING + 1);
   localparam int             DEPTH      = MAX_OUTSTANDING + 1;
   localparam logic [CW:0]    MAX_CREDIT = (CW + 1)'(MAX_OUTSTANDING);

`ifdef FETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   fetch_state    state;
   fetch_state    state_next;
   addr_t         pc;
   addr_t         pc_next;
   logic [CW-1:0] inflight;
   logic [CW-1:0] inflight_next;
   logic [CW-1:0] drop;
   logic [CW-1:0] drop_next;
   logic [CW-1:0] buf_count;
   logic [CW-1:0] buf_count_next;

   logic          req_fire;
   logic          pc_fifo_valid;
   logic          pc_fifo_ready;
   addr_t         pc_head;
   logic          resp_live;
   fetch_packet   resp_pkt;
   logic          buf_in_ready;
   logic          buf_accept;
   logic          buf_pop;

   // Credit covers both in-flight requests and buffered packets, so every
   // response is guaranteed a buffer slot.
   assign mem_req_valid = !rst && (state == RUN) && !redirect_valid && pc_fifo_ready &&
                          (({1'b0, inflight} + {1'b0, buf_count}) < MAX_CREDIT);
   assign mem_req_addr  = pc;
   assign req_fire      = mem_req_valid && mem_req_ready;

   assign resp_live  = mem_resp_valid && pc_fifo_valid && (drop == '0) && !redirect_valid;
   assign resp_pkt   = '{pc: pc_head, instr: mem_resp_data, fault: mem_resp_err};
   assign buf_accept = resp_live && buf_in_ready;
   assign buf_pop    = out_valid && out_ready && !redirect_valid;

   fetch_unit_queue #(
      .DATA_T      (addr_t),
      .DEPTH       (DEPTH),
      .FALLTHROUGH (1'b0),
      .PIPE        (1'b0)
   ) u_pc_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .in_valid  (req_fire),
      .in_ready  (pc_fifo_ready),
      .in_data   (pc),
      .out_valid (pc_fifo_valid),
      .out_ready (mem_resp_valid),
      .out_data  (pc_head)
   );

   fetch_unit_queue #(
      .DATA_T      (fetch_packet),
      .DEPTH       (DEPTH),
      .FALLTHROUGH (BYPASS),
      .PIPE        (1'b0)
   ) u_resp_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .in_valid  (resp_live),
      .in_ready  (buf_in_ready),
      .in_data   (resp_pkt),
      .out_valid (out_valid),
      .out_ready (out_ready && !redirect_valid),
      .out_data  (out_data)
   );

   always_comb begin
      state_next     = state;
      pc_next        = pc;
      inflight_next  = inflight;
      drop_next      = drop;
      buf_count_next = buf_count;
      if (redirect_valid) begin
         // Everything still in flight belongs to the old stream.
         pc_next        = redirect_pc & ~32'h3;
         state_next     = RUN;
         inflight_next  = inflight - CW'(mem_resp_valid);
         drop_next      = inflight - CW'(mem_resp_valid);
         buf_count_next = '0;
      end else begin
         if (req_fire) begin
            pc_next = pc + 32'd4;
         end
         inflight_next  = inflight + CW'(req_fire) - CW'(mem_resp_valid);
         buf_count_next = buf_count + CW'(buf_accept) - CW'(buf_pop);
         if (mem_resp_valid && (drop != '0)) begin
            drop_next = drop - CW'(1);
         end
         if (resp_live && mem_resp_err) begin
            state_next = HALT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         pc        <= RESET_PC;
         inflight  <= '0;
         drop      <= '0;
         buf_count <= '0;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         inflight  <= inflight_next;
         drop      <= drop_next;
         buf_count <= buf_count_next;
      end
   end

   a_resp_needs_inflight : assert property (@(posedge clk) disable iff (rst)
      mem_resp_valid |-> (inflight != '0));
   a_drop_bounded : assert property (@(posedge clk) disable iff (rst)
      drop <= inflight);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit with an in-order memory model.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int          MAXO = 3;
   localparam logic [31:0] KEY  = 32'h5A5A_C3C3;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      addr_t       pc;
      logic [15:0] ep;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid;
   addr_t       redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   addr_t       mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        out_valid;
   logic        out_ready;
   fetch_packet out_data;

   pend_t       pend[$];
   fetch_packet sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   addr_t       model_pc;
   logic [15:0] epoch;
   bit          halt;
   addr_t       err_addr;
   bit          resp_en;
   int          fires;
   int          pops;
   bit          want_first;
   addr_t       exp_first;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_resp();
      if (resp_en && pend.size() > 0) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = pend[0].pc ^ KEY;
         mem_resp_err   = (pend[0].pc == err_addr);
      end else begin
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         mem_resp_err   = 1'b0;
      end
   endtask

   task automatic observe();
      int          sb_pre;
      bit          live;
      bit          exp_req;
      bit          exp_out;
      pend_t       r;
      fetch_packet pkt;
      sb_pre  = sb.size();
      exp_req = !halt && !redirect_valid && ((pend.size() + sb_pre) < MAXO);
      check("req_valid", 96'(mem_req_valid), 96'(exp_req));
      if (mem_req_valid) check("req_addr", 96'(mem_req_addr), 96'(model_pc));
      live = 1'b0;
      if (mem_resp_valid && pend.size() > 0) begin
         r    = pend.pop_front();
         live = (r.ep == epoch) && !redirect_valid;
         if (live) begin
            pkt.pc    = r.pc;
            pkt.instr = r.pc ^ KEY;
            pkt.fault = (r.pc == err_addr);
            sb.push_back(pkt);
            if (pkt.fault) halt = 1'b1;
         end
      end
      if (mem_req_valid && mem_req_ready) begin
         pend.push_back('{pc: model_pc, ep: epoch});
         model_pc += 32'd4;
         fires++;
      end
      exp_out = (sb_pre > 0) || (BYP && live);
      check("out_valid", 96'(out_valid), 96'(exp_out));
      if (out_valid && out_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            check("out_spurious", 96'(out_valid), 96'(0));
         end else begin
            pkt = sb.pop_front();
            pops++;
            check("out_pkt", 96'(out_data), 96'(pkt));
            if (want_first) begin
               check("first_pc", 96'(out_data.pc), 96'(exp_first));
               want_first = 1'b0;
            end
         end
      end
      if (redirect_valid) begin
         epoch++;
         model_pc = redirect_pc & ~32'h3;
         halt     = 1'b0;
         sb.delete();
      end
   endtask

   task automatic run_cycle();
      drive_resp();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      mem_req_ready = 1'b0;
      out_ready     = 1'b1;
      resp_en       = 1'b1;
      n = 0;
      while ((pend.size() + sb.size()) > 0 && n < 40) begin
         run_cycle();
         n++;
      end
      check("drain", 96'(pend.size() + sb.size()), 96'(0));
   endtask

   task automatic do_redirect(input addr_t target, input bit with_resp);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      resp_en        = with_resp;
      run_cycle();
      redirect_valid = 1'b0;
      want_first     = 1'b1;
      exp_first      = target & ~32'h3;
   endtask

   initial begin
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b0;
      out_ready      = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
      model_pc       = 32'h8000_0000;
      epoch          = '0;
      halt           = 1'b0;
      err_addr       = 32'h1;
      resp_en        = 1'b0;
      fires          = 0;
      pops           = 0;
      want_first     = 1'b0;
      exp_first      = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", 96'(mem_req_valid), 96'(0));
      check("rst_out_valid", 96'(out_valid), 96'(0));
      check("rst_addr", 96'(mem_req_addr), 96'(32'h8000_0000));
      @(posedge clk);
      #1 rst = 1'b0;

      // Streaming from reset: one packet per cycle once the pipe fills.
      mem_req_ready = 1'b1;
      out_ready     = 1'b1;
      resp_en       = 1'b1;
      want_first    = 1'b1;
      exp_first     = 32'h8000_0000;
      pops          = 0;
      repeat (12) run_cycle();
      check("stream_rate", 96'(pops), 96'(BYP ? 11 : 10));
      drain();

      // Credit limit with a stalled consumer.
      mem_req_ready = 1'b1;
      out_ready     = 1'b0;
      resp_en       = 1'b1;
      fires         = 0;
      repeat (10) run_cycle();
      check("credit_fires", 96'(fires), 96'(3));
      fires     = 0;
      out_ready = 1'b1;
      run_cycle();
      out_ready = 1'b0;
      repeat (5) run_cycle();
      check("credit_one", 96'(fires), 96'(1));
      drain();

      // Two in flight, then redirect: both responses dropped.
      resp_en       = 1'b0;
      out_ready     = 1'b1;
      mem_req_ready = 1'b1;
      fires         = 0;
      repeat (2) run_cycle();
      mem_req_ready = 1'b0;
      check("two_inflight", 96'(fires), 96'(2));
      do_redirect(32'h0000_0100, 1'b0);
      resp_en       = 1'b1;
      mem_req_ready = 1'b1;
      repeat (8) run_cycle();
      check("first_seen_100", 96'(want_first), 96'(0));
      drain();

      // Three in flight, redirect coincident with a response.
      resp_en       = 1'b0;
      mem_req_ready = 1'b1;
      fires         = 0;
      repeat (3) run_cycle();
      check("three_inflight", 96'(fires), 96'(3));
      mem_req_ready = 1'b0;
      do_redirect(32'h0000_0300, 1'b1);
      mem_req_ready = 1'b1;
      repeat (10) run_cycle();
      check("first_seen_300", 96'(want_first), 96'(0));
      drain();

      // Fault at 0x80000004 halts fetch until a redirect.
      err_addr      = 32'h8000_0004;
      mem_req_ready = 1'b1;
      do_redirect(32'h8000_0000, 1'b1);
      mem_req_ready = 1'b1;
      fires         = 0;
      repeat (10) run_cycle();
      check("halt_fires", 96'(fires), 96'(3));
      check("halt_model", 96'(halt), 96'(1));
      err_addr = 32'h1;
      do_redirect(32'h0000_0200, 1'b1);
      mem_req_ready = 1'b1;
      repeat (8) run_cycle();
      check("first_seen_200", 96'(want_first), 96'(0));
      drain();

      // Unaligned redirect near the top of the address space; PC wraps.
      mem_req_ready = 1'b1;
      do_redirect(32'hFFFF_FFF9, 1'b1);
      mem_req_ready = 1'b1;
      repeat (8) run_cycle();
      drain();

      // Randomised traffic with occasional redirects and faults.
      for (int i = 0; i < 400; i++) begin
         mem_req_ready = ($urandom % 4) != 0;
         resp_en       = ($urandom % 3) != 0;
         out_ready     = ($urandom % 3) != 0;
         if (($urandom % 20) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
            err_addr       = (redirect_pc & ~32'h3) + 32'($urandom_range(0, 6) * 4);
         end
         run_cycle();
         redirect_valid = 1'b0;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
